// File: rtl/count_step_monitor_if.sv
// Bundle between the upstream counter/consumer side and the step monitor.
// The master drives the sample, compare value and acknowledge; the slave returns flags and the event.
interface count_step_monitor_if #(
    parameter int WRAP_W = 8
);
    logic [3:0]        q_in;
    logic [3:0]        cmp;
    logic              ack;
    logic              match;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              evt_valid;
    logic [1:0]        evt_code;
    logic              overrun;
    logic              evt_pend;

    // Event handshake: evt_valid/evt_code hold stable until ack is sampled high
    // while evt_valid is set; ack with evt_valid low has no effect.
    modport master (
        output q_in, cmp, ack,
        input  match, wrap_cnt, evt_valid, evt_code, overrun, evt_pend
    );

    modport slave (
        input  q_in, cmp, ack,
        output match, wrap_cnt, evt_valid, evt_code, overrun, evt_pend
    );
endinterface

// File: rtl/count_step_monitor.sv
// Watches a 4-bit up-counter, classifies each sample against the previous one,
// tallies wraps and presents one pending event at a time to a consumer.
module count_step_monitor #(
    parameter int WRAP_W = 8
) (
    input logic                c,
    input logic                clr,
    count_step_monitor_if.slave bus
);
    typedef enum logic { IDLE = 1'b0, PEND = 1'b1 } evt_state_t;

    localparam logic [1:0]        CODE_NONE  = 2'b00;
    localparam logic [1:0]        CODE_WRAP  = 2'b01;
    localparam logic [1:0]        CODE_JUMP  = 2'b10;
    localparam logic [1:0]        CODE_MATCH = 2'b11;
    localparam logic [WRAP_W-1:0] WRAP_MAX   = '1;

    evt_state_t        state;
    logic [3:0]        prev;
    logic              primed;
    logic              match_q;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic              evt_valid_q;
    logic [1:0]        evt_code_q;
    logic              overrun_q;

    logic [3:0] prev_inc;
    logic       is_hold;
    logic       is_wrap;
    logic       is_step;
    logic       is_jump;
    logic       is_match;
    logic [1:0] new_code;

    assign prev_inc = prev + 4'd1;
    assign is_hold  = (bus.q_in == prev);
    assign is_wrap  = (prev == 4'd15) && (bus.q_in == 4'd0);
    assign is_step  = (bus.q_in == prev_inc) && (prev != 4'd15);
    assign is_jump  = !is_hold && !is_wrap && !is_step;
    assign is_match = (bus.q_in == bus.cmp);

    // The first sample after reset has no valid predecessor, so it raises nothing.
    always_comb begin
        new_code = CODE_NONE;
        if (primed) begin
            if (is_jump)       new_code = CODE_JUMP;
            else if (is_wrap)  new_code = CODE_WRAP;
            else if (is_match) new_code = CODE_MATCH;
        end
    end

    always_ff @(posedge c or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            prev        <= 4'd0;
            primed      <= 1'b0;
            match_q     <= 1'b0;
            wrap_cnt_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= CODE_NONE;
            overrun_q   <= 1'b0;
        end else begin
            prev    <= bus.q_in;
            primed  <= 1'b1;
            match_q <= is_match;

            if (primed && is_wrap && (wrap_cnt_q != WRAP_MAX))
                wrap_cnt_q <= wrap_cnt_q + 1'b1;

            case (state)
                IDLE: begin
                    if (new_code != CODE_NONE) begin
                        state       <= PEND;
                        evt_valid_q <= 1'b1;
                        evt_code_q  <= new_code;
                    end
                end
                PEND: begin
                    if (bus.ack) begin
                        if (new_code != CODE_NONE) begin
                            evt_code_q <= new_code;
                        end else begin
                            state       <= IDLE;
                            evt_valid_q <= 1'b0;
                            evt_code_q  <= CODE_NONE;
                        end
                    end else if (new_code != CODE_NONE) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    evt_valid_q <= 1'b0;
                    evt_code_q  <= CODE_NONE;
                end
            endcase
        end
    end

    assign bus.match     = match_q;
    assign bus.wrap_cnt  = wrap_cnt_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_code  = evt_code_q;
    assign bus.overrun   = overrun_q;
    assign bus.evt_pend  = (state == PEND);
endmodule

// File: doc/count_step_monitor.md
COUNT_STEP_MONITOR -- requirements
Module: count_step_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, width of the wrap-around tally output.
REQ-002 C  input  1  clock; all state updates on the rising edge.
REQ-003 CLR  input  1  reset; asynchronous, active-high.
REQ-004 Q_IN  input  4  unsigned count from the upstream 4-bit up-counter; synchronous to C.
REQ-005 CMP  input  4  compare value for the match flag.
REQ-006 ACK  input  1  event acknowledge from the consumer.
REQ-007 MATCH  output  1  registered; high the cycle after a sample where Q_IN == CMP.
REQ-008 WRAP_CNT  output  WRAP_W  number of 15->0 wraps seen, saturating.
REQ-009 EVT_VALID  output  1  an event is pending for the consumer.
REQ-010 EVT_CODE  output  2  pending event: 01 WRAP, 10 JUMP, 11 MATCH; 00 when EVT_VALID low.
REQ-011 OVERRUN  output  1  sticky; an event was lost while one was pending.

Function
REQ-012 Each rising edge of C shall register Q_IN into PREV and set a PRIMED bit.
REQ-013 When PRIMED is low, the cycle shall update PREV only and classify nothing.
REQ-014 When PRIMED is high, each sample shall be classified against PREV. Classes:
- HOLD: Q_IN == PREV.
- WRAP: PREV == 15 and Q_IN == 0.
- STEP: Q_IN == PREV+1 and PREV != 15.
- JUMP: any other value, i.e. an asynchronous load upstream.
REQ-015 MATCH shall be evaluated on every sample, including the first after reset, independent of PRIMED.
REQ-016 Each WRAP shall increment WRAP_CNT by 1. WRAP_CNT shall saturate at 2^WRAP_W-1 and never roll over.
REQ-017 Event priority within one sample: JUMP > WRAP > MATCH. STEP and HOLD raise no event.
REQ-018 Event FSM has two states, IDLE and PEND:
- IDLE with an event: go to PEND; EVT_VALID=1; EVT_CODE latched; visible one cycle after the sample.
- PEND: EVT_VALID and EVT_CODE shall hold stable until ACK is sampled high.
- PEND with ACK and no new event: go to IDLE.
- PEND with ACK and a same-cycle new event: stay in PEND, load the new code, no overrun.
- PEND with no ACK and a new event: keep the old code and set OVERRUN.
REQ-019 ACK in IDLE shall be ignored.
REQ-020 OVERRUN shall clear only on reset.
REQ-021 WRAP_CNT shall count every WRAP, including WRAPs dropped by the event FSM.

Reset
REQ-022 CLR high shall immediately force the following, regardless of C:
- MATCH=0, WRAP_CNT=0, EVT_VALID=0, EVT_CODE=00, OVERRUN=0.
- PRIMED=0, PREV=0, FSM=IDLE.
REQ-023 Reset asserted mid-PEND shall discard the pending event with no ACK required.
REQ-024 First edge after CLR deasserts: only PREV loads and MATCH is evaluated; no class event is possible.
REQ-025 Latency from a sample to its MATCH, WRAP_CNT or EVT_* effect shall be exactly one cycle.

Verification
REQ-026 CLR, then Q_IN 13,14,15,0,1 on successive edges with ACK tied high:
- WRAP_CNT 0->1 one cycle after the 0 sample.
- EVT_CODE=01 for exactly one cycle.
- OVERRUN=0.
REQ-027 Q_IN 3,4,9 (load to 9), ACK low:
- EVT_VALID=1, EVT_CODE=10.
- Both held for 5 cycles until ACK pulses high, then EVT_VALID=0 the next cycle.
REQ-028 CMP=5, Q_IN 4,5,6, ACK high: MATCH high exactly one cycle, one cycle after the 5 sample; EVT_CODE=11.
REQ-029 Overrun sequence, ACK low:
- JUMP pending, then Q_IN 15,0 (WRAP).
- Required: EVT_CODE stays 10, OVERRUN=1, WRAP_CNT increments.
REQ-030 WRAP_W=2, four full wraps: WRAP_CNT reads 1,2,3,3 (saturated).
REQ-031 Reset mid-operation:
- Assert CLR between edges while PEND: all outputs are zero before the next edge.
- After release, Q_IN 7 then 12: the first sample produces no event; the second produces JUMP.
